// File: rtl/dma_ctrl_sync_fifo.sv
// First-word-fall-through synchronous FIFO for the DMA channel data path.
// The registered RAM read port doubles as the output stage; COUNT = RAM-resident words + VALID.
module dma_ctrl_sync_fifo #(
  parameter int WIDTH         = 128,
  parameter int DEPTH         = 128,
  parameter int ADDR_WIDTH    = $clog2(DEPTH),
  parameter int AFULL_THRESH  = DEPTH - 4,
  parameter int AEMPTY_THRESH = 4
) (
  input  logic                  CLOCK,
  input  logic                  RESET,
  input  logic                  FLUSH,
  input  logic                  WEN,
  input  logic [WIDTH-1:0]      WDATA,
  output logic                  FULL,
  output logic                  AFULL,
  input  logic                  REN,
  output logic [WIDTH-1:0]      RDATA,
  output logic                  VALID,
  output logic                  AEMPTY,
  output logic [ADDR_WIDTH:0]   COUNT,
  input  logic                  CLR_ERR,
  output logic                  OVERFLOW,
  output logic                  UNDERFLOW
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_THRESH);
  localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_THRESH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]    wptr, rptr, ram_cnt, count_next;
  logic             push_ok, pop_ok, rd_issue, ovf_set, unf_set;

  // Requests in a FLUSH cycle are ignored entirely, including error detection.
  always_comb begin
    push_ok    = WEN && !FULL && !FLUSH;
    pop_ok     = REN && VALID && !FLUSH;
    ovf_set    = WEN && FULL && !FLUSH;
    unf_set    = REN && !VALID && !FLUSH;
    ram_cnt    = wptr - rptr;
    rd_issue   = (ram_cnt != '0) && (!VALID || pop_ok) && !FLUSH;
    count_next = COUNT;
    if (FLUSH)
      count_next = '0;
    else if (push_ok && !pop_ok)
      count_next = COUNT + 1'b1;
    else if (pop_ok && !push_ok)
      count_next = COUNT - 1'b1;
  end

  // Storage: write port only, contents intentionally not reset.
  always_ff @(posedge CLOCK) begin
    if (push_ok)
      mem[wptr[ADDR_WIDTH-1:0]] <= WDATA;
  end

  // Output stage: registered RAM read, refilled whenever it is empty or being popped.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET)
      RDATA <= '0;
    else if (rd_issue)
      RDATA <= mem[rptr[ADDR_WIDTH-1:0]];
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      wptr   <= '0;
      rptr   <= '0;
      VALID  <= 1'b0;
      COUNT  <= '0;
      FULL   <= 1'b0;
      AFULL  <= 1'b0;
      AEMPTY <= 1'b1;
    end else begin
      COUNT  <= count_next;
      FULL   <= (count_next == DEPTH_C);
      AFULL  <= (count_next >= AFULL_C);
      AEMPTY <= (count_next <= AEMPTY_C);
      if (FLUSH) begin
        wptr  <= '0;
        rptr  <= '0;
        VALID <= 1'b0;
      end else begin
        if (push_ok)
          wptr <= wptr + 1'b1;
        if (rd_issue) begin
          rptr  <= rptr + 1'b1;
          VALID <= 1'b1;
        end else if (pop_ok) begin
          VALID <= 1'b0;
        end
      end
    end
  end

  // Sticky error flags: a fresh error outranks a simultaneous clear.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      OVERFLOW  <= 1'b0;
      UNDERFLOW <= 1'b0;
    end else begin
      OVERFLOW  <= ovf_set || (OVERFLOW && !CLR_ERR);
      UNDERFLOW <= unf_set || (UNDERFLOW && !CLR_ERR);
    end
  end

endmodule

// File: tb/tb_dma_ctrl_sync_fifo.sv
// Directed bench for dma_ctrl_sync_fifo: stimulus queues expected words,
// a negedge monitor checks every accepted pop against the queue.
module tb_dma_ctrl_sync_fifo;
  localparam int WIDTH = 128;
  localparam int DEPTH = 128;
  localparam int AW    = $clog2(DEPTH);

  logic             CLOCK = 1'b0;
  logic             RESET = 1'b1;
  logic             FLUSH = 1'b0;
  logic             WEN = 1'b0;
  logic [WIDTH-1:0] WDATA = '0;
  logic             FULL, AFULL, VALID, AEMPTY, OVERFLOW, UNDERFLOW;
  logic             REN = 1'b0;
  logic [WIDTH-1:0] RDATA;
  logic [AW:0]      COUNT;
  logic             CLR_ERR = 1'b0;

  int n_vec = 0;
  int n_err = 0;
  logic [WIDTH-1:0] sb [$];

  dma_ctrl_sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .FLUSH(FLUSH), .WEN(WEN), .WDATA(WDATA),
    .FULL(FULL), .AFULL(AFULL), .REN(REN), .RDATA(RDATA), .VALID(VALID),
    .AEMPTY(AEMPTY), .COUNT(COUNT), .CLR_ERR(CLR_ERR),
    .OVERFLOW(OVERFLOW), .UNDERFLOW(UNDERFLOW)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic chk(input string nm, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic push(input logic [WIDTH-1:0] d);
    WEN = 1'b1;
    WDATA = d;
    sb.push_back(d);
  endtask

  // Monitor: REN && VALID seen here is what the next rising edge accepts.
  always @(negedge CLOCK) begin
    if (!RESET && !FLUSH && REN && VALID) begin
      if (sb.size() == 0) begin
        chk("pop_unexpected", RDATA, '1);
      end else begin
        chk("pop_data", RDATA, sb.pop_front());
      end
    end
  end

  initial begin
    // Reset then idle
    tick(); tick();
    RESET = 1'b0;
    tick();
    chk("rst_count", WIDTH'(COUNT), 0);
    chk("rst_valid", WIDTH'(VALID), 0);
    chk("rst_rdata", RDATA, 0);
    chk("rst_aempty", WIDTH'(AEMPTY), 1);
    chk("rst_full", WIDTH'(FULL), 0);
    chk("rst_afull", WIDTH'(AFULL), 0);
    chk("rst_ovf", WIDTH'(OVERFLOW), 0);
    chk("rst_unf", WIDTH'(UNDERFLOW), 0);
    REN = 1'b1;
    tick();
    REN = 1'b0;
    chk("unf_set", WIDTH'(UNDERFLOW), 1);
    chk("unf_count", WIDTH'(COUNT), 0);
    CLR_ERR = 1'b1;
    tick();
    CLR_ERR = 1'b0;
    chk("unf_clr", WIDTH'(UNDERFLOW), 0);

    // Single word latency
    push(128'hA5);
    tick();
    WEN = 1'b0;
    chk("lat_count1", WIDTH'(COUNT), 1);
    chk("lat_valid_e1", WIDTH'(VALID), 0);
    tick();
    chk("lat_valid_e2", WIDTH'(VALID), 1);
    chk("lat_rdata_e2", RDATA, 128'hA5);
    REN = 1'b1;
    tick();
    REN = 1'b0;
    chk("lat_valid_e3", WIDTH'(VALID), 0);
    chk("lat_count_e3", WIDTH'(COUNT), 0);

    // Fill to full, tracking AFULL/AEMPTY thresholds
    for (int i = 0; i < DEPTH; i++) begin
      push(WIDTH'(i));
      tick();
      chk("fill_count", WIDTH'(COUNT), WIDTH'(i + 1));
      chk("fill_afull", WIDTH'(AFULL), WIDTH'((i + 1) >= 124));
      chk("fill_aempty", WIDTH'(AEMPTY), WIDTH'((i + 1) <= 4));
    end
    chk("full_set", WIDTH'(FULL), 1);
    WDATA = 128'h999;
    tick();
    WEN = 1'b0;
    chk("ovf_set", WIDTH'(OVERFLOW), 1);
    chk("ovf_count", WIDTH'(COUNT), 128);
    // Clear and new overflow in the same cycle: the error wins
    WEN = 1'b1;
    CLR_ERR = 1'b1;
    tick();
    WEN = 1'b0;
    chk("ovf_clr_race", WIDTH'(OVERFLOW), 1);
    tick();
    CLR_ERR = 1'b0;
    chk("ovf_clr", WIDTH'(OVERFLOW), 0);

    // Drain all 128
    REN = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      tick();
      chk("drain_count", WIDTH'(COUNT), WIDTH'(DEPTH - 1 - i));
      chk("drain_aempty", WIDTH'(AEMPTY), WIDTH'((DEPTH - 1 - i) <= 4));
      chk("drain_full", WIDTH'(FULL), 0);
    end
    REN = 1'b0;
    chk("drain_valid", WIDTH'(VALID), 0);
    chk("drain_sb_empty", WIDTH'(sb.size()), 0);
    chk("drain_unf", WIDTH'(UNDERFLOW), 0);

    // Half fill then sustained push+pop across pointer wrap
    for (int i = 0; i < 64; i++) begin
      push(WIDTH'(32'h1000 + i));
      tick();
    end
    WEN = 1'b0;
    chk("half_count", WIDTH'(COUNT), 64);
    REN = 1'b1;
    for (int i = 0; i < 300; i++) begin
      push(WIDTH'(32'h2000 + i));
      tick();
      chk("stream_count", WIDTH'(COUNT), 64);
      chk("stream_valid", WIDTH'(VALID), 1);
    end
    WEN = 1'b0;
    for (int i = 0; i < 64; i++) tick();
    REN = 1'b0;
    chk("stream_end_count", WIDTH'(COUNT), 0);
    chk("stream_sb_empty", WIDTH'(sb.size()), 0);

    // Flush with simultaneous push and pop
    for (int i = 0; i < 10; i++) begin
      push(WIDTH'(32'h3000 + i));
      tick();
    end
    WEN = 1'b0;
    chk("pre_flush_count", WIDTH'(COUNT), 10);
    FLUSH = 1'b1;
    WEN = 1'b1;
    REN = 1'b1;
    WDATA = 128'hDEAD;
    sb.delete();
    tick();
    FLUSH = 1'b0;
    WEN = 1'b0;
    REN = 1'b0;
    chk("flush_count", WIDTH'(COUNT), 0);
    chk("flush_valid", WIDTH'(VALID), 0);
    chk("flush_aempty", WIDTH'(AEMPTY), 1);
    chk("flush_ovf", WIDTH'(OVERFLOW), 0);
    chk("flush_unf", WIDTH'(UNDERFLOW), 0);
    push(128'h77);
    tick();
    WEN = 1'b0;
    tick();
    chk("post_flush_valid", WIDTH'(VALID), 1);
    chk("post_flush_rdata", RDATA, 128'h77);
    REN = 1'b1;
    tick();
    REN = 1'b0;
    chk("post_flush_count", WIDTH'(COUNT), 0);

    // Asynchronous reset mid-operation
    for (int i = 0; i < 3; i++) begin
      push(WIDTH'(32'h4000 + i));
      tick();
    end
    WEN = 1'b0;
    tick();
    #2;
    RESET = 1'b1;
    sb.delete();
    #1;
    chk("areset_count", WIDTH'(COUNT), 0);
    chk("areset_valid", WIDTH'(VALID), 0);
    chk("areset_rdata", RDATA, 0);
    chk("areset_aempty", WIDTH'(AEMPTY), 1);
    tick();
    RESET = 1'b0;
    tick();
    chk("areset_idle_count", WIDTH'(COUNT), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/dma_ctrl_sync_fifo.md
# dma_ctrl_sync_fifo

Parametrised synchronous first-word-fall-through FIFO for the DMA controller data path: inferred dual-port RAM with registered read, plus pointer, occupancy, threshold, flush and error-flag logic. It replaces the bare RAM wrapper used by the channel buffers, which has no occupancy tracking. It sits between the AXI read-data capture and the write-out engine of each DMA channel.

## Interface
- WIDTH, 128, data word width in bits
- DEPTH, 128, storage depth in words; power of two, >= 4
- ADDR_WIDTH, $clog2(DEPTH), RAM address / pointer width
- AFULL_THRESH, DEPTH-4, AFULL asserts when COUNT >= this value
- AEMPTY_THRESH, 4, AEMPTY asserts when COUNT <= this value

Ports:
- CLOCK  in  1  single clock, all logic rising-edge
- RESET  in  1  asynchronous, active-high reset
- FLUSH  in  1  synchronous clear of contents
- WEN  in  1  push request
- WDATA  in  WIDTH  push data
- FULL  out  1  COUNT == DEPTH
- AFULL  out  1  almost full
- REN  in  1  pop request; acknowledges current RDATA
- RDATA  out  WIDTH  head-of-FIFO word, valid when VALID=1
- VALID  out  1  RDATA holds a valid word (not-empty)
- AEMPTY  out  1  almost empty
- COUNT  out  ADDR_WIDTH+1  words pushed and not yet popped, 0..DEPTH
- CLR_ERR  in  1  clears OVERFLOW/UNDERFLOW
- OVERFLOW  out  1  sticky: WEN while FULL
- UNDERFLOW  out  1  sticky: REN while !VALID

## Operation
- Push accepted iff WEN && !FULL: write WDATA at wptr, wptr+1 (wraps mod DEPTH). WEN while FULL: data dropped, OVERFLOW set. No pass-through when full, even with simultaneous pop.
- Pop accepted iff REN && VALID. REN while !VALID: ignored, UNDERFLOW set.
- RAM read register is the output stage. Internal ram_cnt = wptr - rptr (ADDR_WIDTH+1 bits, RAM-resident words). Read issued when ram_cnt != 0 && (!VALID || pop accepted): rptr+1, VALID=1 next cycle. If pop accepted and ram_cnt == 0: VALID=0 next cycle. Otherwise RDATA/VALID hold.
- COUNT: +1 on accepted push only, -1 on accepted pop only, unchanged on both or neither. COUNT = ram_cnt + VALID at all times.
- Pointers carry an extra wrap bit; full/empty derived from COUNT, never from pointer equality alone.
- Reads never target an address written the same cycle (ram_cnt uses registered pointers), so no RAM collision mode is required.
- FLUSH (priority over WEN/REN): next cycle wptr=rptr=0, COUNT=0, VALID=0; WEN/REN in the FLUSH cycle ignored and flag no errors. Sticky flags unaffected by FLUSH.
- CLR_ERR clears both sticky flags; a new error in the same cycle wins (flag stays 1).
- AFULL/AEMPTY/FULL are registered and update together with COUNT.

## Timing
- Reset values: COUNT=0, VALID=0, RDATA=0, FULL=0, AFULL=0, AEMPTY=1, OVERFLOW=0, UNDERFLOW=0; pointers 0. RAM contents not reset.
- Reset asserted mid-operation: all state returns to reset values asynchronously; contents lost.
- Write-to-VALID latency on empty FIFO: WEN sampled at edge N, RAM read issued at edge N+1, VALID=1 and RDATA=word after edge N+1.
- Throughput: one push and one pop per cycle sustained; continuous pops with ram_cnt > 0 keep VALID high with a new word every cycle.
- COUNT, FULL, flags: visible the cycle after the causing edge.

## Test plan
- Reset then idle: COUNT=0, VALID=0, AEMPTY=1, FULL=0, all flags 0; REN=1 one cycle -> UNDERFLOW=1, COUNT stays 0.
- Push 0xA5 (WIDTH=128) at edge 1 into empty FIFO -> VALID=1, RDATA=0xA5 after edge 2; REN at edge 3 -> VALID=0, COUNT=0 after edge 3.
- Push 128 words 0..127 -> FULL=1, AFULL=1 from COUNT=124; 129th push -> OVERFLOW=1, COUNT=128; pop all -> data 0..127 in order, no gaps, AEMPTY=1 at COUNT<=4.
- Fill to 64, then push+pop every cycle for 300 cycles -> COUNT constant 64, output sequence intact across pointer wrap.
- COUNT=10 with FLUSH, WEN and REN all high -> COUNT=0, VALID=0 next cycle, no flags; next push seen at RDATA two edges later.
- OVERFLOW=1, CLR_ERR and WEN-while-FULL same cycle -> OVERFLOW stays 1; CLR_ERR alone next cycle -> 0.
